imm_gen_stage: RTL
==================

Name: imm_gen_stage

Overview:
Pipelined, parametrised immediate-generation stage sitting between fetch and the register-read/execute stages. It accepts one instruction plus PC per valid/ready handshake and produces, one cycle later, the XLEN-wide extended immediate, a format code, a branch/jump target (pc+imm) and an illegal-opcode flag. A 2-entry output/skid buffer gives full throughput under back-pressure, and a synchronous flush squashes in-flight entries on redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediates sign-extend to XLEN.
SUPPORT_ZICSR, 1, when 1, SYSTEM opcode with funct3[2]=1 yields zero-extended zimm (instr[19:15]); when 0, SYSTEM is treated as plain I-type.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  synchronous squash of all held entries.
in_valid  input  1  upstream has an instruction.
in_ready  output  1  stage can accept this cycle.
in_instr  input  32  raw instruction.
in_pc  input  XLEN  instruction address.
out_valid  output  1  output entry valid.
out_ready  input  1  downstream accepts.
out_imm  output  XLEN  extended immediate.
out_fmt  output  3  0=I,1=S,2=B,3=U,4=J,5=CSRI,6=R(no imm),7=illegal.
out_target  output  XLEN  out_pc + out_imm, modulo 2^XLEN.
out_pc  output  XLEN  PC of the output entry.
out_illegal  output  1  1 iff out_fmt==7.

Behaviour:
- Decode (combinational on input side, registered into buffer):
  - instr[1:0]!=2'b11 -> illegal.
  - I: 0000011, 0010011, 1100111, 0001111, 1110011 (funct3[2]=0 or SUPPORT_ZICSR=0), 0011011 (XLEN=64 only); imm = sext(instr[31:20]).
  - S: 0100011; sext({instr[31:25],instr[11:7]}).
  - B: 1100011; sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - U: 0110111, 0010111; sext({instr[31:12],12'b0}) (bit 31 replicated above for XLEN=64).
  - J: 1101111; sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - CSRI: 1110011 with funct3[2]=1 and SUPPORT_ZICSR=1; imm = zext(instr[19:15]).
  - R: 0110011, 0111011 (XLEN=64 only); imm = 0.
  - Any other opcode (incl. 0011011/0111011 when XLEN=32) -> fmt 7, imm = 0.
- Target: computed for every entry; meaningful for B, J, AUIPC.
- Buffer: output register (OUT) + skid register (SKID), each with valid bit.
  - in_ready = !skid_valid (registered state, no combinational path from out_ready).
  - Accept when in_valid && in_ready.
  - OUT loads when !out_valid || out_ready: from SKID if skid_valid (SKID clears), else from accepted input, else out_valid->0.
  - Accept while OUT stalled (out_valid && !out_ready) -> entry written to SKID.
  - Accept and SKID drain in the same cycle: SKID->OUT, new input->SKID.
  - Ordering strictly FIFO; latency 1 cycle when unstalled; throughput 1/cycle.
- Flush: clears out_valid and skid_valid next edge; input accepted in flush cycle is dropped; in_ready=1 the following cycle. Flush has priority over all accepts/loads.
- Reset (rst=1 at edge): out_valid=0, skid_valid=0, out_imm=0, out_fmt=0, out_target=0, out_pc=0, out_illegal=0; in_ready=1 after reset. Reset overrides flush and handshakes; mid-stream reset discards held entries.
- Output data held stable while out_valid && !out_ready.

Test Plan:
- XLEN=32: in_instr=0xFE000EE3 (beq -4), in_pc=0x100, out_ready=1 -> next cycle out_fmt=2, out_imm=0xFFFFFFFC, out_target=0x000000FC.
- XLEN=32: in_instr=0x0010006F (jal 2048), in_pc=0x0 -> out_fmt=4, out_imm=0x00000800, out_target=0x800.
- XLEN=64: in_instr=0x800000B7 (lui x1,0x80000) -> out_imm=0xFFFFFFFF80000000, fmt=3; same with XLEN=32 opcode 0x0000001B -> fmt=7, out_illegal=1, imm=0.
- SUPPORT_ZICSR=1: 0x0002D073 (csrrwi, zimm=5) -> fmt=5, imm=5; SUPPORT_ZICSR=0 -> fmt=0, imm=sext(0x000)=0.
- Back-pressure: stream A,B,C with out_ready=0 -> A in OUT, B in SKID, in_ready=0, C held upstream; raise out_ready -> outputs A,B,C in order, no loss/duplication.
- Flush with OUT and SKID full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle input never appears; rst asserted mid-stall gives same empty state with all outputs 0.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes the instruction format, builds the
// XLEN-wide immediate and pc+imm target, and buffers results in a 2-entry skid FIFO.
module imm_gen_stage #(
    parameter int XLEN          = 32,
    parameter bit SUPPORT_ZICSR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_CSRI = 3'd5;
    localparam logic [2:0] FMT_R    = 3'd6;
    localparam logic [2:0] FMT_ILL  = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic [2:0]      fmt;
    } entry_t;

    logic [6:0]      opcode;
    logic            funct3_msb;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;
    entry_t          dec_entry;
    logic            unused_funct;

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   out_load;

    assign opcode       = in_instr[6:0];
    assign funct3_msb   = in_instr[14];
    assign unused_funct = ^in_instr[13:12];

    always_comb begin
        dec_fmt = FMT_ILL;
        dec_imm = '0;
        if (in_instr[1:0] == 2'b11) begin
            case (opcode)
                7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'($signed(in_instr[31:20]));
                end
                7'b1110011: begin
                    if (SUPPORT_ZICSR && funct3_msb) begin
                        dec_fmt = FMT_CSRI;
                        dec_imm = XLEN'(in_instr[19:15]);
                    end else begin
                        dec_fmt = FMT_I;
                        dec_imm = XLEN'($signed(in_instr[31:20]));
                    end
                end
                7'b0011011: begin
                    if (XLEN == 64) begin
                        dec_fmt = FMT_I;
                        dec_imm = XLEN'($signed(in_instr[31:20]));
                    end
                end
                7'b0100011: begin
                    dec_fmt = FMT_S;
                    dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
                end
                7'b1100011: begin
                    dec_fmt = FMT_B;
                    dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                             in_instr[11:8], 1'b0}));
                end
                7'b0110111, 7'b0010111: begin
                    dec_fmt = FMT_U;
                    dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
                end
                7'b1101111: begin
                    dec_fmt = FMT_J;
                    dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                             in_instr[30:21], 1'b0}));
                end
                7'b0110011: begin
                    dec_fmt = FMT_R;
                end
                7'b0111011: begin
                    if (XLEN == 64) begin
                        dec_fmt = FMT_R;
                    end
                end
                default: begin
                    dec_fmt = FMT_ILL;
                end
            endcase
        end
    end

    assign dec_entry.imm    = dec_imm;
    assign dec_entry.target = in_pc + dec_imm;
    assign dec_entry.pc     = in_pc;
    assign dec_entry.fmt    = dec_fmt;

    // in_ready depends only on registered state, so out_ready never reaches upstream combinationally.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign out_load = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_load) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
                if (accept) begin
                    skid_d       = dec_entry;
                    skid_valid_d = 1'b1;
                end
            end else if (accept) begin
                out_d       = dec_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_target  = out_q.target;
    assign out_pc      = out_q.pc;
    assign out_illegal = (out_q.fmt == FMT_ILL);

endmodule
